gs_dram_arb: RTL and testbench

Two-client arbiter sharing the single SDRAM port between the General Sound memory interface (client 0) and a second requester (client 1, e.g. the ROM loader or a DMA engine).
- Latches the winning client's command and drives the shared DRAM request/ack handshake.
- Routes the ACK pulse back to the granted client only.
- Sits between the clients and the SDRAM controller; the controller interface is unchanged.

---
 rtl/gs_dram_arb_pkg.sv | 19 +
 rtl/gs_dram_arb_pick.sv | 31 +++
 rtl/gs_dram_arb.sv | 128 ++++++++++++
 tb/tb_gs_dram_arb.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gs_dram_arb_pkg.sv
// gs_dram_arb_pkg
// Shared definitions for the two-client SDRAM arbiter: FSM state encoding,
// byte-select width and fixed-priority wait counter width.
package gs_dram_arb_pkg;

    // state | meaning
    // IDLE  | no transfer; pick a winner when any request is pending
    // BUSY  | command latched, DRAM_REQ raised until DRAM_ACK
    // REST  | one dead cycle so an acknowledged REQ cannot re-win
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_REST = 2'd2
    } arb_state_t;

    localparam int BSEL_W = 2;
    localparam int WAIT_W = 4;

endpackage

// File: rtl/gs_dram_arb_pick.sv
// gs_dram_arb_pick
// Combinational winner selection for the two-client arbiter.
// Ports:
//   req0, req1  : pending requests from client 0 / client 1
//   last_grant  : client granted most recently
//   fixed_prio  : 1 = client 0 wins ties unless wait_hit is set
//   wait_hit    : client 1 has waited long enough to be forced through
//   any_req     : at least one client is requesting
//   winner      : index of the selected client (valid when any_req)
module gs_dram_arb_pick (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    input  logic fixed_prio,
    input  logic wait_hit,
    output logic any_req,
    output logic winner
);

    always_comb begin
        any_req = req0 | req1;
        winner  = 1'b0;
        if (req0 && req1) begin
            // Tie: round-robin alternates away from the last grant.
            winner = fixed_prio ? wait_hit : ~last_grant;
        end else if (req1) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/gs_dram_arb.sv
// gs_dram_arb
// Arbitrates the single SDRAM port between the General Sound memory
// interface (client 0) and a second requester (client 1). The winning
// command is latched into the DRAM_* registers and held for the whole
// transfer; the controller's ACK is routed back to the granted client only.
// Ports:
//   CLK, RESET          : clock, synchronous active-high reset
//   Cn_ADDR/BSEL/DI/RNW : client command fields
//   Cn_REQ / Cn_ACK     : level request held until the one-cycle ACK
//   C_DO                : read data, DRAM_DO passthrough to both clients
//   DRAM_*              : registered command and handshake to the controller
//   GRANT               : current/last granted client (debug)
//
// state | meaning
// IDLE  | waiting for a request; latch winner's command on entry to BUSY
// BUSY  | DRAM_REQ high until DRAM_ACK; ACK routed to granted client
// REST  | one cycle with all requests ignored
module gs_dram_arb
    import gs_dram_arb_pkg::*;
#(
    parameter int AW         = 24,
    parameter int FIXED_PRIO = 0,
    parameter int MAX_WAIT   = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [AW-1:0]     C0_ADDR,
    input  logic [AW-1:0]     C1_ADDR,
    input  logic [BSEL_W-1:0] C0_BSEL,
    input  logic [BSEL_W-1:0] C1_BSEL,
    input  logic [15:0]       C0_DI,
    input  logic [15:0]       C1_DI,
    input  logic              C0_RNW,
    input  logic              C1_RNW,
    input  logic              C0_REQ,
    input  logic              C1_REQ,
    output logic              C0_ACK,
    output logic              C1_ACK,
    output logic [15:0]       C_DO,
    output logic [AW-1:0]     DRAM_ADDR,
    output logic [BSEL_W-1:0] DRAM_BSEL,
    output logic [15:0]       DRAM_DI,
    output logic              DRAM_RNW,
    output logic              DRAM_REQ,
    input  logic              DRAM_ACK,
    input  logic [15:0]       DRAM_DO,
    output logic              GRANT
);

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic              load;
    logic              any_req;
    logic              winner;
    logic              wait_hit;
    logic [WAIT_W-1:0] wait_cnt;

    assign wait_hit = (wait_cnt >= WAIT_W'(MAX_WAIT));

    gs_dram_arb_pick u_pick (
        .req0       (C0_REQ),
        .req1       (C1_REQ),
        .last_grant (GRANT),
        .fixed_prio (FIXED_PRIO != 0),
        .wait_hit   (wait_hit),
        .any_req    (any_req),
        .winner     (winner)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            GRANT     <= 1'b1;
            wait_cnt  <= '0;
            DRAM_ADDR <= '0;
            DRAM_BSEL <= '0;
            DRAM_DI   <= '0;
            DRAM_RNW  <= 1'b1;
        end else begin
            state_q <= state_d;
            if (load) begin
                GRANT     <= winner;
                DRAM_ADDR <= winner ? C1_ADDR : C0_ADDR;
                DRAM_BSEL <= winner ? C1_BSEL : C0_BSEL;
                DRAM_DI   <= winner ? C1_DI   : C0_DI;
                DRAM_RNW  <= winner ? C1_RNW  : C0_RNW;
                // Counts client-0 grants that made client 1 wait; saturates
                // so it cannot wrap back under MAX_WAIT.
                if (winner || !C1_REQ) begin
                    wait_cnt <= '0;
                end else if (wait_cnt != '1) begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        DRAM_REQ = 1'b0;
        C0_ACK   = 1'b0;
        C1_ACK   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    load    = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Dropping REQ in the ACK cycle keeps the controller from
                // seeing a second transfer.
                DRAM_REQ = ~DRAM_ACK;
                if (DRAM_ACK) begin
                    C0_ACK  = ~GRANT;
                    C1_ACK  = GRANT;
                    state_d = ST_REST;
                end
            end
            ST_REST: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign C_DO = DRAM_DO;

endmodule

// File: tb/tb_gs_dram_arb.sv
module tb_gs_dram_arb;

    localparam int AW         = 24;
    localparam int F_MAX_WAIT = 4;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    logic [AW-1:0] c0_addr, c1_addr;
    logic [1:0]    c0_bsel, c1_bsel;
    logic [15:0]   c0_di, c1_di;
    logic          c0_rnw, c1_rnw;
    logic [15:0]   dram_do;

    // Index 0: round-robin instance, index 1: fixed-priority instance.
    logic          c0_req[2], c1_req[2], dram_ack[2];
    logic          c0_ack[2], c1_ack[2], dram_req[2], dram_rnw[2], grant[2];
    logic [15:0]   c_do[2], dram_di[2];
    logic [AW-1:0] dram_addr[2];
    logic [1:0]    dram_bsel[2];

    int checks = 0;
    int errors = 0;

    // Reference model state
    int last_g[2];
    int wcnt;

    gs_dram_arb #(.AW(AW), .FIXED_PRIO(0), .MAX_WAIT(4)) u_rr (
        .CLK(CLK), .RESET(RESET),
        .C0_ADDR(c0_addr), .C1_ADDR(c1_addr), .C0_BSEL(c0_bsel), .C1_BSEL(c1_bsel),
        .C0_DI(c0_di), .C1_DI(c1_di), .C0_RNW(c0_rnw), .C1_RNW(c1_rnw),
        .C0_REQ(c0_req[0]), .C1_REQ(c1_req[0]), .C0_ACK(c0_ack[0]), .C1_ACK(c1_ack[0]),
        .C_DO(c_do[0]), .DRAM_ADDR(dram_addr[0]), .DRAM_BSEL(dram_bsel[0]),
        .DRAM_DI(dram_di[0]), .DRAM_RNW(dram_rnw[0]), .DRAM_REQ(dram_req[0]),
        .DRAM_ACK(dram_ack[0]), .DRAM_DO(dram_do), .GRANT(grant[0])
    );

    gs_dram_arb #(.AW(AW), .FIXED_PRIO(1), .MAX_WAIT(F_MAX_WAIT)) u_fx (
        .CLK(CLK), .RESET(RESET),
        .C0_ADDR(c0_addr), .C1_ADDR(c1_addr), .C0_BSEL(c0_bsel), .C1_BSEL(c1_bsel),
        .C0_DI(c0_di), .C1_DI(c1_di), .C0_RNW(c0_rnw), .C1_RNW(c1_rnw),
        .C0_REQ(c0_req[1]), .C1_REQ(c1_req[1]), .C0_ACK(c0_ack[1]), .C1_ACK(c1_ack[1]),
        .C_DO(c_do[1]), .DRAM_ADDR(dram_addr[1]), .DRAM_BSEL(dram_bsel[1]),
        .DRAM_DI(dram_di[1]), .DRAM_RNW(dram_rnw[1]), .DRAM_REQ(dram_req[1]),
        .DRAM_ACK(dram_ack[1]), .DRAM_DO(dram_do), .GRANT(grant[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Arbitration rules: single requester wins; on a tie round-robin picks the
    // client not granted last, fixed priority picks client 0 unless client 1
    // has already been passed over MAX_WAIT times.
    function automatic int predict(input int d, input logic r0, input logic r1);
        if (r0 && r1) begin
            if (d == 1) return (wcnt >= F_MAX_WAIT) ? 1 : 0;
            return 1 - last_g[d];
        end
        return r1 ? 1 : 0;
    endfunction

    task automatic model_reset();
        last_g[0] = 1;
        last_g[1] = 1;
        wcnt      = 0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        model_reset();
    endtask

    task automatic rand_fields();
        c0_addr = AW'($urandom);
        c1_addr = AW'($urandom);
        c0_bsel = 2'($urandom);
        c1_bsel = 2'($urandom);
        c0_di   = 16'($urandom);
        c1_di   = 16'($urandom);
        c0_rnw  = 1'($urandom);
        c1_rnw  = 1'($urandom);
    endtask

    // Acts as the SDRAM controller for one transfer on instance d.
    // hold: 0 = winner drops REQ after ACK, 1 = winner keeps REQ one extra
    // cycle, 2 = requests left untouched (continuous requesters).
    task automatic serve(input int d, input int lat, input logic [15:0] dov, input int hold,
                         input bit scramble, output int win, output int wait_n);
        logic r0, r1, erw;
        logic [AW-1:0] ea;
        logic [1:0] eb;
        logic [15:0] edi;
        int n;
        r0  = c0_req[d];
        r1  = c1_req[d];
        win = predict(d, r0, r1);
        ea  = (win == 1) ? c1_addr : c0_addr;
        eb  = (win == 1) ? c1_bsel : c0_bsel;
        edi = (win == 1) ? c1_di   : c0_di;
        erw = (win == 1) ? c1_rnw  : c0_rnw;
        n = 0;
        while (dram_req[d] !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        wait_n = n;
        chk("dram_req_seen", dram_req[d], 1);
        if (dram_req[d] !== 1'b1) return;
        last_g[d] = win;
        if (d == 1) begin
            if (win == 1 || !r1) wcnt = 0;
            else wcnt++;
        end
        chk("grant", grant[d], win);
        chk("addr", dram_addr[d], ea);
        chk("bsel", dram_bsel[d], eb);
        chk("di", dram_di[d], edi);
        chk("rnw", dram_rnw[d], erw);
        if (scramble) rand_fields();
        for (int i = 0; i < lat; i++) begin
            @(negedge CLK);
            chk("req_held", dram_req[d], 1);
        end
        dram_do     = dov;
        dram_ack[d] = 1'b1;
        #1;
        chk("req_drop_on_ack", dram_req[d], 0);
        chk("c0_ack", c0_ack[d], (win == 0) ? 1 : 0);
        chk("c1_ack", c1_ack[d], (win == 1) ? 1 : 0);
        chk("c_do", c_do[d], dov);
        chk("addr_stable", dram_addr[d], ea);
        chk("di_stable", dram_di[d], edi);
        chk("rnw_stable", dram_rnw[d], erw);
        chk("bsel_stable", dram_bsel[d], eb);
        @(negedge CLK);
        dram_ack[d] = 1'b0;
        if (hold == 0) begin
            if (win == 1) c1_req[d] = 1'b0;
            else c0_req[d] = 1'b0;
        end
        #1;
        chk("c0_ack_pulse", c0_ack[d], 0);
        chk("c1_ack_pulse", c1_ack[d], 0);
        chk("rest_no_req", dram_req[d], 0);
        if (hold == 1) begin
            @(negedge CLK);
            if (win == 1) c1_req[d] = 1'b0;
            else c0_req[d] = 1'b0;
            chk("no_dup_a", dram_req[d], 0);
            @(negedge CLK);
            chk("no_dup_b", dram_req[d], 0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int win, wn, n;
        int fx_seq[10];
        fx_seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        RESET = 1'b1;
        c0_addr = '0; c1_addr = '0; c0_bsel = '0; c1_bsel = '0;
        c0_di = '0; c1_di = '0; c0_rnw = 1'b1; c1_rnw = 1'b1;
        dram_do = '0;
        for (int d = 0; d < 2; d++) begin
            c0_req[d] = 1'b0; c1_req[d] = 1'b0; dram_ack[d] = 1'b0;
        end
        model_reset();
        repeat (3) @(negedge CLK);

        // Reset values
        for (int d = 0; d < 2; d++) begin
            chk("rst_dram_req", dram_req[d], 0);
            chk("rst_c0_ack", c0_ack[d], 0);
            chk("rst_c1_ack", c1_ack[d], 0);
            chk("rst_grant", grant[d], 1);
            chk("rst_addr", dram_addr[d], 0);
            chk("rst_bsel", dram_bsel[d], 0);
            chk("rst_di", dram_di[d], 0);
            chk("rst_rnw", dram_rnw[d], 1);
        end
        RESET = 1'b0;

        // Single read from client 0, ACK four cycles after DRAM_REQ
        @(negedge CLK);
        c0_addr = 24'h100000; c0_rnw = 1'b1; c0_bsel = 2'b11;
        c0_req[0] = 1'b1;
        serve(0, 4, 16'hA55A, 0, 1'b0, win, wn);
        chk("rd_latency", wn, 1);
        chk("rd_addr_final", dram_addr[0], 24'h100000);

        // Round-robin, both clients requesting continuously
        do_reset();
        for (int i = 0; i < 6; i++) begin
            rand_fields();
            c0_req[0] = 1'b1; c1_req[0] = 1'b1;
            serve(0, $urandom_range(0, 3), 16'($urandom), 2, 1'b0, win, wn);
            chk("rr_seq", grant[0], i % 2);
            if (i > 0) chk("rr_gap", wn, 2);
        end
        c0_req[0] = 1'b0; c1_req[0] = 1'b0;

        // Fixed priority with MAX_WAIT=4, both requesting
        do_reset();
        for (int i = 0; i < 10; i++) begin
            rand_fields();
            c0_req[1] = 1'b1; c1_req[1] = 1'b1;
            serve(1, $urandom_range(0, 3), 16'($urandom), 2, 1'b0, win, wn);
            chk("fx_seq", grant[1], fx_seq[i]);
        end
        c0_req[1] = 1'b0; c1_req[1] = 1'b0;

        // Client-1 write; inputs change while BUSY
        @(negedge CLK);
        @(negedge CLK);
        rand_fields();
        c1_bsel = 2'b10; c1_di = 16'h1234; c1_rnw = 1'b0;
        c1_req[0] = 1'b1;
        serve(0, 3, 16'($urandom), 0, 1'b1, win, wn);
        chk("wr_rnw", dram_rnw[0], 0);
        chk("wr_bsel", dram_bsel[0], 2'b10);
        chk("wr_di", dram_di[0], 16'h1234);
        chk("wr_grant", grant[0], 1);

        // Reset in BUSY, then a late DRAM_ACK
        @(negedge CLK);
        @(negedge CLK);
        rand_fields();
        c0_req[0] = 1'b1;
        n = 0;
        while (dram_req[0] !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("mid_req_seen", dram_req[0], 1);
        RESET = 1'b1;
        @(negedge CLK);
        chk("mid_rst_req", dram_req[0], 0);
        chk("mid_rst_grant", grant[0], 1);
        RESET = 1'b0;
        model_reset();
        c0_req[0] = 1'b0;
        dram_ack[0] = 1'b1;
        dram_do = 16'hBEEF;
        #1;
        chk("late_ack_c0", c0_ack[0], 0);
        chk("late_ack_c1", c1_ack[0], 0);
        chk("late_ack_req", dram_req[0], 0);
        @(negedge CLK);
        dram_ack[0] = 1'b0;
        chk("late_ack_c0_b", c0_ack[0], 0);
        rand_fields();
        c1_req[0] = 1'b1;
        serve(0, 2, 16'($urandom), 0, 1'b0, win, wn);
        chk("post_rst_latency", wn, 1);

        // Client keeps REQ one cycle past ACK
        @(negedge CLK);
        rand_fields();
        c0_req[0] = 1'b1;
        serve(0, 1, 16'($urandom), 1, 1'b0, win, wn);

        // Randomized request patterns on the round-robin instance
        for (int i = 0; i < 20; i++) begin
            int m;
            m = $urandom_range(1, 3);
            rand_fields();
            c0_req[0] = m[0];
            c1_req[0] = m[1];
            serve(0, $urandom_range(0, 4), 16'($urandom), 0, 1'($urandom), win, wn);
        end
        c0_req[0] = 1'b0; c1_req[0] = 1'b0;

        repeat (2) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
